dpram_sync: RTL and testbench

- Parametrised single-clock true dual-port RAM; replaces fixed 512x8 vendor-primitive wrappers with one inferable block.
- Generic over data width, depth, read latency and per-port write mode.
- Adds cross-port collision detection, read-valid tracking and an optional post-reset clear sequencer.
- Used for the display, FIFO and mailbox buffers between the Z80 bus side and the ESP/SPI side.

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_sync_if.sv | 18 +
 rtl/dpram_port_out.sv | 90 +++++++++
 rtl/dpram_sync.sv | 155 +++++++++++++++
 tb/tb_dpram_sync.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants and types for the dpram_sync RAM.
// Write-mode encodings, the clear-sequencer state type and the
// read-latency legality check used at elaboration.
package dpram_pkg;

    localparam int WM_NORMAL            = 0;
    localparam int WM_WRITE_THROUGH     = 1;
    localparam int WM_READ_BEFORE_WRITE = 2;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    function automatic bit read_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/dpram_sync_if.sv
// dpram_sync_if: one RAM access port (enable, write, address, data,
// output-register enable) plus its read data and valid flag.
// master = the client driving the port, slave = the RAM.
interface dpram_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    logic              ce;
    logic              wre;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic              oce;
    logic [DATA_W-1:0] dout;
    logic              valid;

    modport master (output ce, wre, ad, din, oce, input dout, valid);
    modport slave  (input ce, wre, ad, din, oce, output dout, valid);
endinterface

// File: rtl/dpram_port_out.sv
// dpram_port_out: read-data path of one RAM port.
// Stage 1 picks the array word, the write data or a hold depending on the
// write mode; with READ_LAT=2 an oce-gated output register follows.
module dpram_port_out
    import dpram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int WRITE_MODE = WM_NORMAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] rdata,
    input  logic              oce,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic [DATA_W-1:0] data_p1_q, data_p1_d;
    logic              vld_p1_q, vld_p1_d;

    // Stage 1 select: reads return the array word, writes follow the write mode
    always_comb begin
        data_p1_d = data_p1_q;
        vld_p1_d  = 1'b0;
        if (ce) begin
            if (!we) begin
                data_p1_d = rdata;
                vld_p1_d  = 1'b1;
            end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
                data_p1_d = din;
                vld_p1_d  = 1'b1;
            end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
                data_p1_d = rdata;
                vld_p1_d  = 1'b1;
            end
        end
    end

    // Stage 1 register; reset drops any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            data_p1_q <= data_p1_d;
            vld_p1_q  <= vld_p1_d;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_oreg
            logic [DATA_W-1:0] data_p2_q, data_p2_d;
            logic              vld_p2_q, vld_p2_d;

            // Output stage: load stage 1 only when oce is high, else freeze
            always_comb begin
                data_p2_d = data_p2_q;
                vld_p2_d  = vld_p2_q;
                if (oce) begin
                    data_p2_d = data_p1_q;
                    vld_p2_d  = vld_p1_q;
                end
            end

            // Output register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_p2_q <= '0;
                    vld_p2_q  <= 1'b0;
                end else begin
                    data_p2_q <= data_p2_d;
                    vld_p2_q  <= vld_p2_d;
                end
            end

            assign dout  = data_p2_q;
            assign valid = vld_p2_q;
        end else begin : g_direct
            logic unused_oce;
            assign unused_oce = oce;
            assign dout       = data_p1_q;
            assign valid      = vld_p1_q;
        end
    endgenerate

endmodule

// File: rtl/dpram_sync.sv
// dpram_sync: single-clock true dual-port RAM with per-port write mode,
// read-first cross-port behaviour, port-A write priority and a collision flag.
// Optional feature macro DPRAM_SYNC_CLEAR_EN: after reset an internal
// sequencer zeroes every word (one per cycle) while busy is high.
module dpram_sync
    import dpram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 9,
    parameter int READ_LAT     = 1,
    parameter int WRITE_MODE_A = WM_NORMAL,
    parameter int WRITE_MODE_B = WM_NORMAL
) (
    input  logic         clk,
    input  logic         reset,
    dpram_sync_if.slave  pa,
    dpram_sync_if.slave  pb,
    output logic         collision,
    output logic         busy
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
            $fatal(1, "dpram_sync: READ_LAT must be 1 or 2");
        end
        if (DATA_W < 1 || DATA_W > 36) begin : g_bad_width
            $fatal(1, "dpram_sync: DATA_W must be 1..36");
        end
        if (WRITE_MODE_A < 0 || WRITE_MODE_A > 2 || WRITE_MODE_B < 0 || WRITE_MODE_B > 2) begin : g_bad_mode
            $fatal(1, "dpram_sync: WRITE_MODE must be 0, 1 or 2");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_active;
    logic              acc_a, acc_b, we_a, we_b;
    logic              wa_en, wb_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic [DATA_W-1:0] old_a, old_b;
    logic              collision_q, collision_d;

`ifdef DPRAM_SYNC_CLEAR_EN
    clr_state_t        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Clear sequencer state: restarts from address 0 on every reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_state_q <= CLR_RUN;
            clr_cnt_q   <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    // Clear sequencer next state: step the address, stop after the last word
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        if (clr_state_q == CLR_RUN) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                clr_state_d = CLR_IDLE;
            end
        end
    end

    assign clr_active = (clr_state_q == CLR_RUN);
`else
    assign clr_active = 1'b0;
`endif

    assign busy  = clr_active;
    assign old_a = mem_q[pa.ad];
    assign old_b = mem_q[pb.ad];

    // Access qualification, port-A write priority and clear-write override
    always_comb begin
        acc_a       = pa.ce & ~clr_active;
        acc_b       = pb.ce & ~clr_active;
        we_a        = acc_a & pa.wre;
        we_b        = acc_b & pb.wre;
        wa_en       = we_a;
        wa_addr     = pa.ad;
        wa_data     = pa.din;
        wb_en       = we_b & ~(we_a & (pa.ad == pb.ad));
        collision_d = acc_a & acc_b & (pa.ad == pb.ad) & (pa.wre | pb.wre);
`ifdef DPRAM_SYNC_CLEAR_EN
        if (clr_active) begin
            wa_en   = 1'b1;
            wa_addr = clr_cnt_q;
            wa_data = '0;
        end
`endif
    end

    // Array writes; reads above see the pre-edge contents (read-first)
    always_ff @(posedge clk) begin
        if (wb_en) begin
            mem_q[pb.ad] <= pb.din;
        end
        if (wa_en) begin
            mem_q[wa_addr] <= wa_data;
        end
    end

    // Collision flag: one-cycle pulse after the conflicting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    dpram_port_out #(
        .DATA_W     (DATA_W),
        .READ_LAT   (READ_LAT),
        .WRITE_MODE (WRITE_MODE_A)
    ) u_out_a (
        .clk   (clk),
        .reset (reset),
        .ce    (acc_a),
        .we    (we_a),
        .din   (pa.din),
        .rdata (old_a),
        .oce   (pa.oce),
        .dout  (pa.dout),
        .valid (pa.valid)
    );

    dpram_port_out #(
        .DATA_W     (DATA_W),
        .READ_LAT   (READ_LAT),
        .WRITE_MODE (WRITE_MODE_B)
    ) u_out_b (
        .clk   (clk),
        .reset (reset),
        .ce    (acc_b),
        .we    (we_b),
        .din   (pb.din),
        .rdata (old_b),
        .oce   (pb.oce),
        .dout  (pb.dout),
        .valid (pb.valid)
    );

endmodule

// File: tb/tb_dpram_sync.sv
// tb_dpram_sync: three RAM instances (READ_LAT=1 NORMAL/WRITE_THROUGH,
// READ_LAT=2 READ_BEFORE_WRITE/NORMAL, and a 16-word one for the clear
// sequencer) checked against word-array reference models.
module tb_dpram_sync;
    import dpram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dpram_sync_if #(.DATA_W(8), .ADDR_W(9)) ifa0 ();
    dpram_sync_if #(.DATA_W(8), .ADDR_W(9)) ifb0 ();
    dpram_sync_if #(.DATA_W(8), .ADDR_W(9)) ifa1 ();
    dpram_sync_if #(.DATA_W(8), .ADDR_W(9)) ifb1 ();
    dpram_sync_if #(.DATA_W(8), .ADDR_W(4)) ifa2 ();
    dpram_sync_if #(.DATA_W(8), .ADDR_W(4)) ifb2 ();
    logic coll0, busy0, coll1, busy1, coll2, busy2;

    dpram_sync #(.DATA_W(8), .ADDR_W(9), .READ_LAT(1),
                 .WRITE_MODE_A(WM_NORMAL), .WRITE_MODE_B(WM_WRITE_THROUGH))
        dut0 (.clk(clk), .reset(reset), .pa(ifa0), .pb(ifb0), .collision(coll0), .busy(busy0));
    dpram_sync #(.DATA_W(8), .ADDR_W(9), .READ_LAT(2),
                 .WRITE_MODE_A(WM_READ_BEFORE_WRITE), .WRITE_MODE_B(WM_NORMAL))
        dut1 (.clk(clk), .reset(reset), .pa(ifa1), .pb(ifb1), .collision(coll1), .busy(busy1));
    dpram_sync #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1),
                 .WRITE_MODE_A(WM_NORMAL), .WRITE_MODE_B(WM_NORMAL))
        dut2 (.clk(clk), .reset(reset), .pa(ifa2), .pb(ifb2), .collision(coll2), .busy(busy2));

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] m0 [512];
    logic [7:0] m1 [512];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa0.ce = 0; ifa0.wre = 0; ifa0.oce = 1; ifb0.ce = 0; ifb0.wre = 0; ifb0.oce = 1;
        ifa1.ce = 0; ifa1.wre = 0; ifa1.oce = 1; ifb1.ce = 0; ifb1.wre = 0; ifb1.oce = 1;
        ifa2.ce = 0; ifa2.wre = 0; ifa2.oce = 1; ifb2.ce = 0; ifb2.wre = 0; ifb2.oce = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 | busy1 | busy2) !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        n_total++;
        if (n >= 3000) $display("FAIL wait_idle: busy still %b%b%b after %0d cycles, required 000", busy0, busy1, busy2, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        ifa0.ad = '0; ifa0.din = '0; ifb0.ad = '0; ifb0.din = '0;
        ifa1.ad = '0; ifa1.din = '0; ifb1.ad = '0; ifb1.din = '0;
        ifa2.ad = '0; ifa2.din = '0; ifb2.ad = '0; ifb2.din = '0;
        tick();
        tick();
        n_total++;
        if ({ifa0.dout, ifa0.valid, ifb0.dout, ifb0.valid, coll0} !== 19'd0)
            $display("FAIL reset_dut0: got %h/%b %h/%b coll %b, required all 0", ifa0.dout, ifa0.valid, ifb0.dout, ifb0.valid, coll0);
        else n_pass++;
        n_total++;
        if ({ifa1.dout, ifa1.valid, ifb1.dout, ifb1.valid, coll1} !== 19'd0)
            $display("FAIL reset_dut1: got %h/%b %h/%b coll %b, required all 0", ifa1.dout, ifa1.valid, ifb1.dout, ifb1.valid, coll1);
        else n_pass++;
        reset = 1'b0;
        n_total++;
`ifdef DPRAM_SYNC_CLEAR_EN
        if (busy0 !== 1'b1) $display("FAIL reset_busy: got %b, required 1", busy0);
`else
        if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy0);
`endif
        else n_pass++;
        wait_idle();
    endtask

    task automatic prefill();
        logic [7:0] d0, d1;
        for (int a = 0; a < 512; a++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            ifa0.ce = 1; ifa0.wre = 1; ifa0.ad = 9'(a); ifa0.din = d0;
            ifa1.ce = 1; ifa1.wre = 1; ifa1.ad = 9'(a); ifa1.din = d1;
            m0[a] = d0;
            m1[a] = d1;
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_basic();
        ifa0.ce = 1; ifa0.wre = 1; ifa0.ad = 9'h010; ifa0.din = 8'h5A;
        tick();
        m0[9'h010] = 8'h5A;
        n_total++;
        if (ifa0.valid !== 1'b0) $display("FAIL basic_write_valid: got %b, required 0", ifa0.valid);
        else n_pass++;
        ifa0.wre = 0;
        tick();
        n_total++;
        if (ifa0.dout !== 8'h5A || ifa0.valid !== 1'b1)
            $display("FAIL basic_read: got %h/%b, required 5a/1", ifa0.dout, ifa0.valid);
        else n_pass++;
        idle_all();
        tick();
        n_total++;
        if (ifa0.dout !== 8'h5A || ifa0.valid !== 1'b0)
            $display("FAIL basic_idle: got %h/%b, required 5a/0", ifa0.dout, ifa0.valid);
        else n_pass++;
    endtask

    task automatic test_cross_read_first();
        ifb0.ce = 1; ifb0.wre = 1; ifb0.ad = 9'h020; ifb0.din = 8'h22;
        tick();
        m0[9'h020] = 8'h22;
        n_total++;
        if (ifb0.dout !== 8'h22 || ifb0.valid !== 1'b1)
            $display("FAIL b_write_through: got %h/%b, required 22/1", ifb0.dout, ifb0.valid);
        else n_pass++;
        ifa0.ce = 1; ifa0.wre = 1; ifa0.ad = 9'h020; ifa0.din = 8'h11;
        ifb0.ce = 1; ifb0.wre = 0; ifb0.ad = 9'h020;
        tick();
        n_total++;
        if (ifb0.dout !== 8'h22 || coll0 !== 1'b1)
            $display("FAIL cross_old_word: got %h coll %b, required 22 coll 1", ifb0.dout, coll0);
        else n_pass++;
        m0[9'h020] = 8'h11;
        idle_all();
        tick();
        n_total++;
        if (coll0 !== 1'b0) $display("FAIL cross_coll_pulse: got %b, required 0", coll0);
        else n_pass++;
        ifb0.ce = 1; ifb0.wre = 0; ifb0.ad = 9'h020;
        tick();
        n_total++;
        if (ifb0.dout !== 8'h11) $display("FAIL cross_new_word: got %h, required 11", ifb0.dout);
        else n_pass++;
        idle_all();
    endtask

    task automatic test_both_write();
        ifa0.ce = 1; ifa0.wre = 1; ifa0.ad = 9'h030; ifa0.din = 8'hAA;
        ifb0.ce = 1; ifb0.wre = 1; ifb0.ad = 9'h030; ifb0.din = 8'hBB;
        tick();
        m0[9'h030] = 8'hAA;
        n_total++;
        if (coll0 !== 1'b1 || ifb0.dout !== 8'hBB)
            $display("FAIL both_write: coll %b doutb %h, required coll 1 doutb bb", coll0, ifb0.dout);
        else n_pass++;
        idle_all();
        tick();
        n_total++;
        if (coll0 !== 1'b0) $display("FAIL both_write_pulse: got %b, required 0", coll0);
        else n_pass++;
        ifa0.ce = 1; ifa0.wre = 0; ifa0.ad = 9'h030;
        tick();
        n_total++;
        if (ifa0.dout !== 8'hAA) $display("FAIL both_write_stored: got %h, required aa", ifa0.dout);
        else n_pass++;
        idle_all();
    endtask

    task automatic test_write_modes();
        logic [7:0] old40;
        ifa0.ce = 1; ifa0.wre = 0; ifa0.ad = 9'h010;
        tick();
        ifa0.wre = 1; ifa0.ad = 9'h040; ifa0.din = 8'h3C;
        ifb0.ce = 1; ifb0.wre = 1; ifb0.ad = 9'h041; ifb0.din = 8'h3C;
        old40 = m1[9'h040];
        ifa1.ce = 1; ifa1.wre = 1; ifa1.ad = 9'h040; ifa1.din = 8'h3C; ifa1.oce = 1;
        tick();
        m0[9'h040] = 8'h3C;
        m0[9'h041] = 8'h3C;
        m1[9'h040] = 8'h3C;
        n_total++;
        if (ifa0.dout !== m0[9'h010] || ifa0.valid !== 1'b0)
            $display("FAIL wm_normal: got %h/%b, required %h/0", ifa0.dout, ifa0.valid, m0[9'h010]);
        else n_pass++;
        n_total++;
        if (ifb0.dout !== 8'h3C || ifb0.valid !== 1'b1 || coll0 !== 1'b0)
            $display("FAIL wm_write_through: got %h/%b coll %b, required 3c/1 coll 0", ifb0.dout, ifb0.valid, coll0);
        else n_pass++;
        idle_all();
        tick();
        n_total++;
        if (ifa1.dout !== old40 || ifa1.valid !== 1'b1)
            $display("FAIL wm_read_before_write: got %h/%b, required %h/1", ifa1.dout, ifa1.valid, old40);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] ea, eb, da, db;
        logic       va, vb, ec, ca, cb, wa, wb;
        logic [8:0] aa, ab;
        ifa0.ce = 1; ifa0.wre = 0; ifa0.ad = '0;
        ifb0.ce = 1; ifb0.wre = 0; ifb0.ad = '0;
        tick();
        ea = m0[0]; eb = m0[0];
        n_total++;
        if (ifa0.dout !== ea || ifb0.dout !== eb || coll0 !== 1'b0)
            $display("FAIL rand_same_read: got %h %h coll %b, required %h %h coll 0", ifa0.dout, ifb0.dout, coll0, ea, eb);
        else n_pass++;
        for (int i = 0; i < 300; i++) begin
            ca = 1'($urandom); cb = 1'($urandom); wa = 1'($urandom); wb = 1'($urandom);
            aa = 9'($urandom_range(0, 7)); ab = 9'($urandom_range(0, 7));
            da = 8'($urandom); db = 8'($urandom);
            ifa0.ce = ca; ifa0.wre = wa; ifa0.ad = aa; ifa0.din = da;
            ifb0.ce = cb; ifb0.wre = wb; ifb0.ad = ab; ifb0.din = db;
            va = 1'b0;
            vb = 1'b0;
            if (ca && !wa) begin ea = m0[aa]; va = 1'b1; end
            if (cb) begin eb = wb ? db : m0[ab]; vb = 1'b1; end
            ec = ca && cb && (aa == ab) && (wa || wb);
            if (cb && wb && !(ca && wa && aa == ab)) m0[ab] = db;
            if (ca && wa) m0[aa] = da;
            tick();
            n_total++;
            if (ifa0.valid !== va || (va && ifa0.dout !== ea) || (!wa && ifa0.dout !== ea))
                $display("FAIL rand_a[%0d]: got %h/%b, required %h/%b", i, ifa0.dout, ifa0.valid, ea, va);
            else n_pass++;
            n_total++;
            if (ifb0.valid !== vb || ifb0.dout !== eb)
                $display("FAIL rand_b[%0d]: got %h/%b, required %h/%b", i, ifb0.dout, ifb0.valid, eb, vb);
            else n_pass++;
            n_total++;
            if (coll0 !== ec) $display("FAIL rand_coll[%0d]: got %b, required %b", i, coll0, ec);
            else n_pass++;
        end
        idle_all();
        tick();
    endtask

    task automatic test_oce();
        logic [7:0] old10;
        old10 = m1[9'h010];
        ifa1.ce = 1; ifa1.wre = 1; ifa1.ad = 9'h010; ifa1.din = 8'h5A; ifa1.oce = 1;
        tick();
        m1[9'h010] = 8'h5A;
        idle_all();
        tick();
        tick();
        ifa1.ce = 1; ifa1.wre = 0; ifa1.ad = 9'h010; ifa1.oce = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (ifa1.dout !== old10 || ifa1.valid !== 1'b0)
                $display("FAIL oce_frozen[%0d]: got %h/%b, required %h/0", i, ifa1.dout, ifa1.valid, old10);
            else n_pass++;
        end
        ifa1.ce = 0; ifa1.oce = 1;
        tick();
        n_total++;
        if (ifa1.dout !== 8'h5A || ifa1.valid !== 1'b1)
            $display("FAIL oce_release: got %h/%b, required 5a/1", ifa1.dout, ifa1.valid);
        else n_pass++;
        ifa1.ce = 1;
        tick();
        ifa1.ce = 0;
        reset = 1'b1;
        #1;
        n_total++;
        if (ifa1.dout !== 8'h00 || ifa1.valid !== 1'b0)
            $display("FAIL reset_mid_read: got %h/%b, required 00/0", ifa1.dout, ifa1.valid);
        else n_pass++;
        tick();
        reset = 1'b0;
        wait_idle();
    endtask

    task automatic test_clear();
`ifdef DPRAM_SYNC_CLEAR_EN
        int n;
        int bad_v;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifa2.ce = 1; ifa2.wre = 1; ifa2.ad = 4'd3; ifa2.din = 8'hFF;
        n = 0;
        bad_v = 0;
        while (busy2 === 1'b1 && n < 100) begin
            tick();
            n++;
            if (ifa2.valid !== 1'b0) bad_v++;
        end
        idle_all();
        n_total++;
        if (n != 16) $display("FAIL clear_len: got %0d cycles, required 16", n);
        else n_pass++;
        n_total++;
        if (bad_v != 0) $display("FAIL clear_valid: got %0d valid cycles, required 0", bad_v);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            ifa2.ce = 1; ifa2.wre = 0; ifa2.ad = 4'(a);
            tick();
            n_total++;
            if (ifa2.dout !== 8'h00 || ifa2.valid !== 1'b1)
                $display("FAIL clear_word[%0d]: got %h/%b, required 00/1", a, ifa2.dout, ifa2.valid);
            else n_pass++;
        end
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        #1;
        n_total++;
        if (busy2 !== 1'b1) $display("FAIL clear_restart_busy: got %b, required 1", busy2);
        else n_pass++;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_total++;
        if (n != 16) $display("FAIL clear_restart_len: got %0d cycles, required 16", n);
        else n_pass++;
        wait_idle();
`else
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (busy2 !== 1'b0 || coll2 !== 1'b0)
                $display("FAIL busy_tied[%0d]: busy %b coll %b, required 0 0", i, busy2, coll2);
            else n_pass++;
        end
`endif
    endtask

    initial begin
        test_reset();
        prefill();
        test_basic();
        test_cross_read_first();
        test_both_write();
        test_write_modes();
        test_random();
        test_oce();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
